uart_core: RTL and testbench

- Parametrised full-duplex UART: transmitter plus oversampling receiver in one block.
- Successor to the fixed 8N1, TX-only UART top. Adds configurable baud, data width, parity and stop bits, a valid/ready TX handshake, and an RX path with error and overrun reporting.
- Connects fabric logic to the board serial pins; runs entirely in the sys_clk domain.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_core.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_uart_core.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM states and the oversample ratio.
// Used by both the transmit and receive paths of uart_core.
package uart_pkg;

    localparam int PAR_NONE   = 0;
    localparam int PAR_ODD    = 1;
    localparam int PAR_EVEN   = 2;
    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every DIV clocks.
// clr restarts the count so a frame's bit grid aligns to its trigger.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || clr) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: framed transmitter with valid/ready input and a
// 16x oversampling receiver with parity, framing and overrun reporting.
module uart_core #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int OS_DIV    = CLK_FREQ / (BAUD * uart_pkg::OVERSAMPLE)
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy,
    output logic                 uart_tx,
    input  logic                 uart_rx,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    import uart_pkg::*;

    generate
        if (OS_DIV < 1 || DATA_BITS < 5 || DATA_BITS > 9 ||
            PARITY < 0 || PARITY > 2 ||
            STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
            $error("uart_core: illegal parameter set");
        end
    endgenerate

    localparam logic [3:0] OS_LAST   = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] OS_MID    = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic       PAR_EN    = (PARITY != PAR_NONE);
    localparam logic       PAR_INV   = (PARITY == PAR_ODD);

    uart_state_t          r_tx_state;
    logic [3:0]           r_tx_os;
    logic [3:0]           r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 r_tx_line;
    logic                 w_tx_tick;
    logic                 w_tx_accept;

    assign w_tx_accept = tx_valid && (r_tx_state == IDLE);
    assign tx_ready    = (r_tx_state == IDLE);
    assign tx_busy     = (r_tx_state != IDLE);
    assign uart_tx     = r_tx_line;

    uart_baud_tick #(.DIV(OS_DIV)) u_tx_tick (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (w_tx_accept),
        .tick      (w_tx_tick)
    );

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_tx_state <= IDLE;
            r_tx_os    <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_line  <= 1'b1;
        end else begin
            unique case (r_tx_state)
                IDLE: begin
                    if (w_tx_accept) begin
                        r_tx_shift <= tx_data;
                        r_tx_par   <= (^tx_data) ^ PAR_INV;
                        r_tx_os    <= '0;
                        r_tx_bit   <= '0;
                        r_tx_line  <= 1'b0;
                        r_tx_state <= START;
                    end
                end
                START: begin
                    if (w_tx_tick) begin
                        r_tx_os <= r_tx_os + 1'b1;
                        if (r_tx_os == OS_LAST) begin
                            r_tx_line  <= r_tx_shift[0];
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_tx_tick) begin
                        r_tx_os <= r_tx_os + 1'b1;
                        if (r_tx_os == OS_LAST) begin
                            if (r_tx_bit == BIT_LAST) begin
                                r_tx_bit <= '0;
                                if (PAR_EN) begin
                                    r_tx_line  <= r_tx_par;
                                    r_tx_state <= uart_pkg::PARITY;
                                end else begin
                                    r_tx_line  <= 1'b1;
                                    r_tx_state <= STOP;
                                end
                            end else begin
                                r_tx_bit   <= r_tx_bit + 1'b1;
                                r_tx_line  <= r_tx_shift[0];
                                r_tx_shift <= r_tx_shift >> 1;
                            end
                        end
                    end
                end
                uart_pkg::PARITY: begin
                    if (w_tx_tick) begin
                        r_tx_os <= r_tx_os + 1'b1;
                        if (r_tx_os == OS_LAST) begin
                            r_tx_line  <= 1'b1;
                            r_tx_state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (w_tx_tick) begin
                        r_tx_os <= r_tx_os + 1'b1;
                        if (r_tx_os == OS_LAST) begin
                            if (r_tx_bit == STOP_LAST) begin
                                r_tx_state <= IDLE;
                            end else begin
                                r_tx_bit <= r_tx_bit + 1'b1;
                            end
                        end
                    end
                end
                default: r_tx_state <= IDLE;
            endcase
        end
    end

    uart_state_t          r_rx_state;
    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic                 r_rx_prev;
    logic [3:0]           r_rx_os;
    logic [3:0]           r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par_bit;
    logic                 r_rx_stop_err;
    logic                 r_rx_valid;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_perr;
    logic                 r_rx_ferr;
    logic                 r_rx_ovr;
    logic                 w_rx_tick;
    logic                 w_rx_edge;
    logic                 w_rx_clr;
    logic                 w_rx_sample;
    logic                 w_rx_done;
    logic                 w_rx_perr;
    logic                 w_rx_ferr;

    assign w_rx_edge   = r_rx_prev && !r_rx_sync;
    assign w_rx_clr    = (r_rx_state == IDLE) && w_rx_edge;
    assign w_rx_sample = w_rx_tick && (r_rx_os == OS_LAST);
    assign w_rx_done   = (r_rx_state == STOP) && w_rx_sample &&
                         (r_rx_bit == STOP_LAST);
    assign w_rx_perr   = PAR_EN &&
                         (((^r_rx_shift) ^ PAR_INV) != r_rx_par_bit);
    assign w_rx_ferr   = r_rx_stop_err || !r_rx_sync;

    assign rx_valid      = r_rx_valid;
    assign rx_data       = r_rx_data;
    assign rx_parity_err = r_rx_perr;
    assign rx_frame_err  = r_rx_ferr;
    assign rx_overrun    = r_rx_ovr;

    uart_baud_tick #(.DIV(OS_DIV)) u_rx_tick (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (w_rx_clr),
        .tick      (w_rx_tick)
    );

    // Sync chain idles high so reset release never looks like a start edge
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_rx_state    <= IDLE;
            r_rx_os       <= '0;
            r_rx_bit      <= '0;
            r_rx_shift    <= '0;
            r_rx_par_bit  <= 1'b0;
            r_rx_stop_err <= 1'b0;
        end else begin
            unique case (r_rx_state)
                IDLE: begin
                    if (w_rx_edge) begin
                        r_rx_os       <= '0;
                        r_rx_bit      <= '0;
                        r_rx_stop_err <= 1'b0;
                        r_rx_state    <= START;
                    end
                end
                START: begin
                    if (w_rx_tick) begin
                        r_rx_os <= r_rx_os + 1'b1;
                        if (r_rx_os == OS_MID) begin
                            r_rx_os    <= '0;
                            r_rx_state <= r_rx_sync ? IDLE : DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_rx_tick) begin
                        r_rx_os <= r_rx_os + 1'b1;
                    end
                    if (w_rx_sample) begin
                        r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_bit == BIT_LAST) begin
                            r_rx_bit   <= '0;
                            r_rx_state <= PAR_EN ? uart_pkg::PARITY : STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 1'b1;
                        end
                    end
                end
                uart_pkg::PARITY: begin
                    if (w_rx_tick) begin
                        r_rx_os <= r_rx_os + 1'b1;
                    end
                    if (w_rx_sample) begin
                        r_rx_par_bit <= r_rx_sync;
                        r_rx_state   <= STOP;
                    end
                end
                STOP: begin
                    if (w_rx_tick) begin
                        r_rx_os <= r_rx_os + 1'b1;
                    end
                    if (w_rx_sample) begin
                        if (r_rx_bit == STOP_LAST) begin
                            r_rx_state <= IDLE;
                        end else begin
                            r_rx_bit      <= r_rx_bit + 1'b1;
                            r_rx_stop_err <= r_rx_stop_err || !r_rx_sync;
                        end
                    end
                end
                default: r_rx_state <= IDLE;
            endcase
        end
    end

    // A completion coinciding with rx_ready is a read plus a load
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_rx_perr  <= 1'b0;
            r_rx_ferr  <= 1'b0;
            r_rx_ovr   <= 1'b0;
        end else begin
            r_rx_ovr <= 1'b0;
            if (w_rx_done) begin
                r_rx_data  <= r_rx_shift;
                r_rx_perr  <= w_rx_perr;
                r_rx_ferr  <= w_rx_ferr;
                r_rx_valid <= 1'b1;
                r_rx_ovr   <= r_rx_valid && !rx_ready;
            end else if (rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: three instances (8N1, odd/2-stop,
// even-parity loopback) checked against a frame-level reference model.
module tb_uart_core;

    localparam int CPB = 16;

    typedef bit bitq_t[$];

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;

    logic       tv0 = 1'b0, tr0, tb0, tx0, rx0 = 1'b1;
    logic [7:0] td0 = '0, rd0;
    logic       rv0, rr0 = 1'b0, pe0, fe0, ov0;

    logic       tv1 = 1'b0, tr1, tb1, tx1, rx1 = 1'b1;
    logic [7:0] td1 = '0, rd1;
    logic       rv1, rr1 = 1'b0, pe1, fe1, ov1;

    logic       tv2 = 1'b0, tr2, tb2, tx2;
    logic [7:0] td2 = '0, rd2;
    logic       rv2, rr2 = 1'b1, pe2, fe2, ov2;

    int errors = 0;
    int checks = 0;
    int ov_cnt0 = 0;
    logic [9:0] q2[$];

    always #5 clk = ~clk;

    uart_core #(.CLK_FREQ(16_000_000), .BAUD(1_000_000), .DATA_BITS(8),
                .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .tx_valid(tv0), .tx_ready(tr0), .tx_data(td0), .tx_busy(tb0),
        .uart_tx(tx0), .uart_rx(rx0),
        .rx_valid(rv0), .rx_ready(rr0), .rx_data(rd0),
        .rx_parity_err(pe0), .rx_frame_err(fe0), .rx_overrun(ov0)
    );

    uart_core #(.CLK_FREQ(16_000_000), .BAUD(1_000_000), .DATA_BITS(8),
                .PARITY(1), .STOP_BITS(2)) u_dut1 (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .tx_valid(tv1), .tx_ready(tr1), .tx_data(td1), .tx_busy(tb1),
        .uart_tx(tx1), .uart_rx(rx1),
        .rx_valid(rv1), .rx_ready(rr1), .rx_data(rd1),
        .rx_parity_err(pe1), .rx_frame_err(fe1), .rx_overrun(ov1)
    );

    uart_core #(.CLK_FREQ(16_000_000), .BAUD(1_000_000), .DATA_BITS(8),
                .PARITY(2), .STOP_BITS(1)) u_dut2 (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .tx_valid(tv2), .tx_ready(tr2), .tx_data(td2), .tx_busy(tb2),
        .uart_tx(tx2), .uart_rx(tx2),
        .rx_valid(rv2), .rx_ready(rr2), .rx_data(rd2),
        .rx_parity_err(pe2), .rx_frame_err(fe2), .rx_overrun(ov2)
    );

    always @(negedge clk) begin
        if (ov0) ov_cnt0++;
        if (rv2 && rr2) q2.push_back({fe2, pe2, rd2});
    end

    // Reference frame: start, data LSB first, optional parity, stop bits
    function automatic bitq_t mk_frame(logic [7:0] d, int par, int stops,
                                       bit flip_par, bit bad_stop);
        bitq_t q;
        int ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (par != 0) begin
            bit p;
            p = (par == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
            q.push_back(p ^ flip_par);
        end
        for (int s = 0; s < stops; s++)
            q.push_back(!(bad_stop && s == stops - 1));
        return q;
    endfunction

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_frame(int which, bitq_t q);
        foreach (q[i]) begin
            if (which == 0) rx0 = q[i];
            else rx1 = q[i];
            step(CPB);
        end
        if (which == 0) rx0 = 1'b1;
        else rx1 = 1'b1;
        step(CPB);
    endtask

    task automatic wait_rv(int which, int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((which == 0) ? rv0 : rv1) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        checks++;
        if ({tx0, tb0, tr0} !== 3'b101) begin
            errors++;
            $display("FAIL reset_tx {tx,busy,ready} got=%b exp=101",
                     {tx0, tb0, tr0});
        end
        checks++;
        if ({rv0, rd0, pe0, fe0, ov0} !== 12'h000) begin
            errors++;
            $display("FAIL reset_rx {v,data,pe,fe,ov} got=%h exp=000",
                     {rv0, rd0, pe0, fe0, ov0});
        end
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_tx_8n1();
        logic [7:0] w;
        bitq_t q;
        int bad, first;
        for (int t = 0; t < 5; t++) begin
            w = (t == 0) ? 8'hA5 : 8'($urandom);
            q = mk_frame(w, 0, 1, 1'b0, 1'b0);
            tv0 = 1'b1;
            td0 = w;
            step(1);
            tv0 = 1'b0;
            bad = 0;
            first = -1;
            for (int k = 0; k <= 160; k++) begin
                logic exp_tx;
                exp_tx = (k < 160) ? q[k / 16] : 1'b1;
                if (tx0 !== exp_tx || tb0 !== (k < 160) ||
                    (k < 159 && tr0 !== 1'b0)) begin
                    bad++;
                    if (first < 0) first = k;
                end
                if (k == 159) begin
                    checks++;
                    if (tr0 !== 1'b0) begin
                        errors++;
                        $display("FAIL tx_ready_early got=%b exp=0", tr0);
                    end
                end
                if (k == 160) begin
                    checks++;
                    if (tr0 !== 1'b1) begin
                        errors++;
                        $display("FAIL tx_ready_160 got=%b exp=1", tr0);
                    end
                end
                if (k < 160) step(1);
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL tx_wave word=%h bad_cycles=%0d exp=0 first=%0d",
                         w, bad, first);
            end
        end
    endtask

    task automatic test_loopback();
        logic [7:0] w[6];
        int n;
        w[0] = 8'h3C;
        w[1] = 8'h81;
        for (int i = 2; i < 6; i++) w[i] = 8'($urandom);
        q2.delete();
        rr2 = 1'b1;
        tv2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            td2 = w[i];
            n = 0;
            while (!tr2 && n < 400) begin
                step(1);
                n++;
            end
            if (i > 0) begin
                checks++;
                if (n != 176) begin
                    errors++;
                    $display("FAIL b2b_gap word=%0d got=%0d exp=176", i, n);
                end
            end
            step(1);
            checks++;
            if ({tr2, tx2} !== 2'b00) begin
                errors++;
                $display("FAIL b2b_start {ready,tx} got=%b exp=00", {tr2, tx2});
            end
        end
        tv2 = 1'b0;
        n = 0;
        while (q2.size() < 6 && n < 1500) begin
            step(1);
            n++;
        end
        checks++;
        if (q2.size() != 6) begin
            errors++;
            $display("FAIL loop_count got=%0d exp=6", q2.size());
        end
        for (int i = 0; i < 6 && i < q2.size(); i++) begin
            checks++;
            if (q2[i] !== {2'b00, w[i]}) begin
                errors++;
                $display("FAIL loop_word idx=%0d got=%h exp=%h",
                         i, q2[i], {2'b00, w[i]});
            end
        end
    endtask

    task automatic test_parity_err();
        logic [7:0] w[4];
        bit fp[4], bs[4];
        bit ok;
        w[0] = 8'h0F; fp[0] = 0; bs[0] = 0;
        w[1] = 8'h0F; fp[1] = 1; bs[1] = 0;
        w[2] = 8'hA3; fp[2] = 0; bs[2] = 1;
        w[3] = 8'($urandom); fp[3] = 1; bs[3] = 1;
        rr1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_frame(1, mk_frame(w[i], 1, 2, fp[i], bs[i]));
            wait_rv(1, 40, ok);
            checks++;
            if (!ok || {rd1, pe1, fe1} !== {w[i], fp[i], bs[i]}) begin
                errors++;
                $display("FAIL odd_rx idx=%0d got=v%b %h pe%b fe%b exp=%h pe%b fe%b",
                         i, rv1, rd1, pe1, fe1, w[i], fp[i], bs[i]);
            end
            rr1 = 1'b1;
            step(1);
            rr1 = 1'b0;
            checks++;
            if (rv1 !== 1'b0) begin
                errors++;
                $display("FAIL odd_read_clear got=%b exp=0", rv1);
            end
        end
    endtask

    task automatic test_frame_glitch();
        bit ok;
        rr0 = 1'b0;
        drive_frame(0, mk_frame(8'h55, 0, 1, 1'b0, 1'b1));
        wait_rv(0, 40, ok);
        checks++;
        if (!ok || {rd0, pe0, fe0} !== {8'h55, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL frame_err got=v%b %h pe%b fe%b exp=55 pe0 fe1",
                     rv0, rd0, pe0, fe0);
        end
        rr0 = 1'b1;
        step(1);
        rr0 = 1'b0;
        rx0 = 1'b0;
        step(5);
        rx0 = 1'b1;
        step(40);
        checks++;
        if (rv0 !== 1'b0) begin
            errors++;
            $display("FAIL glitch_valid got=%b exp=0", rv0);
        end
        drive_frame(0, mk_frame(8'h5A, 0, 1, 1'b0, 1'b0));
        wait_rv(0, 40, ok);
        checks++;
        if (!ok || {rd0, pe0, fe0} !== {8'h5A, 2'b00}) begin
            errors++;
            $display("FAIL after_glitch got=v%b %h pe%b fe%b exp=5a pe0 fe0",
                     rv0, rd0, pe0, fe0);
        end
        rr0 = 1'b1;
        step(1);
        rr0 = 1'b0;
    endtask

    task automatic test_overrun();
        rr0 = 1'b0;
        ov_cnt0 = 0;
        drive_frame(0, mk_frame(8'h11, 0, 1, 1'b0, 1'b0));
        drive_frame(0, mk_frame(8'h22, 0, 1, 1'b0, 1'b0));
        checks++;
        if (ov_cnt0 != 1) begin
            errors++;
            $display("FAIL overrun_pulses got=%0d exp=1", ov_cnt0);
        end
        checks++;
        if ({rv0, rd0, pe0, fe0} !== {1'b1, 8'h22, 2'b00}) begin
            errors++;
            $display("FAIL overrun_word got=v%b %h pe%b fe%b exp=v1 22 pe0 fe0",
                     rv0, rd0, pe0, fe0);
        end
        rr0 = 1'b1;
        step(1);
        rr0 = 1'b0;
        checks++;
        if (rv0 !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear got=%b exp=0", rv0);
        end
    endtask

    task automatic test_rx_random();
        logic [7:0] w;
        bit ok;
        rr0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w = 8'($urandom);
            step($urandom_range(0, 20));
            drive_frame(0, mk_frame(w, 0, 1, 1'b0, 1'b0));
            wait_rv(0, 40, ok);
            checks++;
            if (!ok || {rd0, pe0, fe0} !== {w, 2'b00}) begin
                errors++;
                $display("FAIL rx_rand idx=%0d got=v%b %h pe%b fe%b exp=%h",
                         i, rv0, rd0, pe0, fe0, w);
            end
            rr0 = 1'b1;
            step(1);
            rr0 = 1'b0;
        end
    endtask

    task automatic test_reset_midframe();
        bitq_t q;
        int bad;
        rr0 = 1'b0;
        drive_frame(0, mk_frame(8'h3B, 0, 1, 1'b0, 1'b0));
        tv0 = 1'b1;
        td0 = 8'h00;
        step(1);
        tv0 = 1'b0;
        step(40);
        rst_n = 1'b0;
        step(1);
        checks++;
        if ({tx0, tr0, tb0, rv0, rd0} !== {4'b1100, 8'h00}) begin
            errors++;
            $display("FAIL mid_reset {tx,rdy,busy,rv,rd} got=%b exp=110000000000",
                     {tx0, tr0, tb0, rv0, rd0});
        end
        rst_n = 1'b1;
        step(2);
        q = mk_frame(8'hFF, 0, 1, 1'b0, 1'b0);
        tv0 = 1'b1;
        td0 = 8'hFF;
        step(1);
        tv0 = 1'b0;
        bad = 0;
        for (int k = 0; k < 160; k++) begin
            if (tx0 !== q[k / 16] || tr0 !== 1'b0) bad++;
            step(1);
        end
        checks++;
        if (bad != 0 || tr0 !== 1'b1) begin
            errors++;
            $display("FAIL ff_after_reset bad_cycles=%0d ready=%b exp=0 ready=1",
                     bad, tr0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_tx_8n1();
        test_loopback();
        test_parity_err();
        test_frame_glitch();
        test_overrun();
        test_rx_random();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
